// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default geometry for the data-memory arbiter.
// The enum drives the controller FSM. The defaults size the attached DataMemory port.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 14;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Round-robin winner selection. The requester after the last granted one has top priority.
// The pointer moves only when the owner accepts the winner (advance_i).
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_req_o
);

  localparam logic [IDX_W:0]   N_L      = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic [N_REQ-1:0] rot_req;
  logic [IDX_W-1:0] rot_idx [N_REQ];

  // Slot gi holds the requester that sits gi+1 places after the last winner.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W:0] pos_sum;
    assign pos_sum      = {1'b0, last_q} + (IDX_W+1)'(gi + 1);
    assign rot_idx[gi]  = (pos_sum >= N_L) ? IDX_W'(pos_sum - N_L) : pos_sum[IDX_W-1:0];
    assign rot_req[gi]  = req_i[rot_idx[gi]];
  end

  always_comb begin
    win_idx_o = '0;
    any_req_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_idx_o = rot_idx[k];
        any_req_o = 1'b1;
      end
    end
  end

  always_comb begin
    win_onehot_o = '0;
    if (any_req_o) begin
      win_onehot_o[win_idx_o] = 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && any_req_o) begin
      last_d = win_idx_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port DataMemory between N_REQ requesters.
// The FSM runs ACCESS for every grant and adds RESP only for an in-range read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        we_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*DATA_W-1:0] wdata_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    busy_o,
  output logic                    mem_enable,
  output logic                    mem_write_enable,
  output logic                    mem_read_enable,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_input_data,
  input  logic [DATA_W-1:0]       mem_output_data
);

  localparam int             IDX_W   = $clog2(N_REQ);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e state_q;
  state_e state_d;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              any_req;
  logic              load;
  logic [ADDR_W-1:0] win_addr;
  logic              win_oor;

  logic [N_REQ-1:0]  owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
    assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .advance_i    (load),
    .win_onehot_o (win_onehot),
    .win_idx_o    (win_idx),
    .any_req_o    (any_req)
  );

  // Requester inputs are only looked at on the edge that enters ACCESS.
  assign load     = (state_d == ACCESS);
  assign win_addr = addr_arr[win_idx];
  assign win_oor  = ({1'b0, win_addr} >= DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? ACCESS : IDLE;
      ACCESS: begin
        if (!we_q && !oor_q) begin
          state_d = RESP;
        end else begin
          state_d = any_req ? ACCESS : IDLE;
        end
      end
      RESP:    state_d = any_req ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    if (load) begin
      owner_d = win_onehot;
      we_d    = we_i[win_idx];
      addr_d  = win_addr;
      wdata_d = wdata_arr[win_idx];
      oor_d   = win_oor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
    end
  end

  // Every pulse is decoded from state_q, so reset clears it immediately.
  always_comb begin
    gnt_o            = '0;
    err_o            = '0;
    rvalid_o         = '0;
    rdata_o          = '0;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    busy_o           = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        gnt_o = owner_q;
        if (oor_q) begin
          err_o = owner_q;
        end else begin
          mem_enable       = 1'b1;
          mem_write_enable = we_q;
          mem_read_enable  = !we_q;
        end
      end
      RESP: begin
        rvalid_o = owner_q;
        rdata_o  = mem_output_data;
      end
      default: ;
    endcase
  end

  assign mem_address    = addr_q;
  assign mem_input_data = wdata_q;

endmodule
